dp_rr_sequencer: RTL



---
 rtl/dp_seq_pkg.sv | 19 +
 rtl/dp_rr_arbiter.sv | 47 ++++
 rtl/dp_rr_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dp_seq_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin datapath sequencer.
package dp_seq_pkg;

    localparam int DP_IN_W  = 4;
    localparam int DP_OUT_W = 38;
    localparam int STATS_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Saturating increment used by the optional transaction counter.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] value);
        return (value == {STATS_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/dp_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at pointer+1 and wraps
// from NUM_REQ-1 back to 0, so the last winner gets lowest priority next time.
module dp_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // Requester index examined at search position gi (position 0 = pointer+1).
    logic [ID_W-1:0] cand_idx [NUM_REQ];

    // pointer and offset are both below NUM_REQ, so one conditional subtract wraps.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int off);
        int sum;
        sum = int'(p) + 1 + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = wrap_idx(pointer, gi);
        end
    endgenerate

    // First valid requester in search order wins.
    always_comb begin
        logic found;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand_idx[k]]) begin
                found             = 1'b1;
                grant_idx         = cand_idx[k];
                grant[cand_idx[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_rr_sequencer.sv
// Round-robin sequencer sharing one external combinational datapath among
// NUM_REQ requesters: accept an operand, drive it from a register, wait DP_LAT
// cycles for the datapath to settle, then present the tagged result until taken.
// Optional feature macro: DP_SEQ_STATS_EN adds a saturating result counter (txn_count).
module dp_rr_sequencer
    import dp_seq_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DP_LAT  = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DP_IN_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DP_IN_W-1:0]           dp_in,
    input  logic [DP_OUT_W-1:0]          dp_out,
    output logic                         res_valid,
    output logic [DP_OUT_W-1:0]          res_data,
    output logic [ID_W-1:0]              res_id,
    input  logic                         res_ready,
    output logic                         busy
`ifdef DP_SEQ_STATS_EN
    ,
    output logic [STATS_W-1:0]           txn_count
`endif
);

    // Counter only needs to hold DP_LAT-1; keep at least one bit.
    localparam int                CNT_W    = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DP_LAT - 1);
    // Pointer starts on the last requester so requester 0 is searched first.
    localparam logic [ID_W-1:0]   PTR_RST  = ID_W'(NUM_REQ - 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [ID_W-1:0]        ptr_reg;
    logic [ID_W-1:0]        id_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [DP_IN_W-1:0]     dp_in_reg;
    logic                   res_valid_reg;
    logic [DP_OUT_W-1:0]    res_data_reg;
    logic [ID_W-1:0]        res_id_reg;

    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grant_idx;
    logic                   accept;
    logic                   capture;
    logic                   release_res;

    // Per-requester operand view of the packed request bus.
    logic [DP_IN_W-1:0]     req_operand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operand
            assign req_operand[gi] = req_data[DP_IN_W*gi +: DP_IN_W];
        end
    endgenerate

    dp_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .req       (req_valid),
        .pointer   (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Next-state logic and handshake strobes; grants are only offered in IDLE.
    always_comb begin
        state_next  = state_reg;
        req_ready   = '0;
        busy        = (state_reg != IDLE);
        accept      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = grant;
                if (|(req_valid & grant)) begin
                    accept     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_valid_reg && res_ready) begin
                    release_res = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the accepted operand, its owner and the new round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_in_reg <= '0;
            id_reg    <= '0;
            ptr_reg   <= PTR_RST;
        end else if (accept) begin
            dp_in_reg <= req_operand[grant_idx];
            id_reg    <= grant_idx;
            ptr_reg   <= grant_idx;
        end
    end

    // Settle counter: loaded on accept, counts down while the datapath settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= CNT_LOAD;
        end else if (state_reg == SETTLE && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // Result register: capture once settled, hold until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_id_reg    <= '0;
        end else if (capture) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= dp_out;
            res_id_reg    <= id_reg;
        end else if (release_res) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign dp_in     = dp_in_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;

`ifdef DP_SEQ_STATS_EN
    logic [STATS_W-1:0] txn_count_reg;

    // Count completed result handshakes, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_reg <= '0;
        end else if (release_res) begin
            txn_count_reg <= sat_inc(txn_count_reg);
        end
    end

    assign txn_count = txn_count_reg;
`endif

endmodule
